// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the RV32I-subset multicycle core:
//                opcode constants, control FSM state enum, ALU operation
//                encodings and datapath mux select encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  // Control FSM states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // ALU operation codes
  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_sll = 4'b0011;
  localparam logic [3:0] c_alu_xor = 4'b0100;
  localparam logic [3:0] c_alu_srl = 4'b0101;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_slt = 4'b0111;

  // Memory address source
  localparam logic       c_adr_pc     = 1'b0;
  localparam logic       c_adr_aluout = 1'b1;

  // Result mux
  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_rdata  = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  // ALU operand A mux
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_a     = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] c_srcb_b     = 2'b00;
  localparam logic [1:0] c_srcb_imm   = 2'b01;
  localparam logic [1:0] c_srcb_four  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle between the multicycle control FSM and the datapath.
//                master : control unit (consumes instruction fields / flags,
//                         drives selects and strobes)
//                slave  : datapath side
//  Signals     : opcode[6:0], funct3[2:0], funct7[6:0], zero, mem_ready  (to control)
//                pc_write, adr_src, ir_write, mem_write, reg_write,
//                result_src[1:0], alu_src_a[1:0], alu_src_b[1:0],
//                alu_control[3:0], instr_retired, illegal              (from control)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic       instr_retired;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control,
           instr_retired, illegal
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control,
           instr_retired, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational funct3/funct7 decode to ALU operation for
//                register and immediate ALU instructions.
//  Ports       : i_funct3[2:0]   instr[14:12]
//                i_funct7b5      instr[30]
//                i_op5           opcode[5] (1 = register form)
//                o_alu_control   ALU operation code
//                o_unsupported   high for SLTU and SRA encodings
//  Revision    : 1.0  initial release
// ============================================================================
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [3:0] o_alu_control,
  output logic       o_unsupported
);

  always_comb begin
    o_alu_control = c_alu_add;
    o_unsupported = 1'b0;
    case (i_funct3)
      // Immediate form never subtracts: instr[30] is an immediate bit there
      3'b000: if (i_op5 && i_funct7b5) o_alu_control = c_alu_sub;
      3'b001: o_alu_control = c_alu_sll;
      3'b010: o_alu_control = c_alu_slt;
      3'b011: o_unsupported = 1'b1;
      3'b100: o_alu_control = c_alu_xor;
      3'b101: begin
        o_alu_control = c_alu_srl;
        if (i_funct7b5) o_unsupported = 1'b1;
      end
      3'b110: o_alu_control = c_alu_or;
      3'b111: o_alu_control = c_alu_and;
      default: o_alu_control = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle control FSM for the RV32I-subset core. Produces
//                per-cycle mux selects, write strobes and ALU operation for
//                a datapath that shares one ALU and one memory port.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    multicycle_control_if.master (fields/flags in,
//                       selects/strobes/status out)
//  Config      : MC_CTRL_ILLEGAL_TRAP_EN  when defined, unsupported
//                instructions park the FSM in HALT and raise sticky
//                'illegal'; otherwise they retire as NOP / execute as ADD.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
  import riscv_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  state_t     r_state;
  state_t     w_next;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_retired;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu_control;

  logic [3:0] w_dec_alu;
  logic       w_dec_unsup;
  logic [3:0] w_exec_alu;

  alu_decoder u_alu_decoder (
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7[5]),
    .i_op5         (bus.opcode[5]),
    .o_alu_control (w_dec_alu),
    .o_unsupported (w_dec_unsup)
  );

  // Unsupported funct combinations fall back to ADD
  assign w_exec_alu = w_dec_unsup ? c_alu_add : w_dec_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_retired     = 1'b0;
    w_adr_src     = c_adr_pc;
    w_result_src  = c_res_aluout;
    w_alu_src_a   = c_srca_pc;
    w_alu_src_b   = c_srcb_b;
    w_alu_control = c_alu_add;

    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU to PC while the instruction loads
        w_alu_src_b  = c_srcb_four;
        w_result_src = c_res_alu;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch/jump target into ALUOut
        w_alu_src_a = c_srca_oldpc;
        w_alu_src_b = c_srcb_imm;
        case (bus.opcode)
          c_op_load,
          c_op_store:  w_next = S_MEMADR;
          c_op_rtype:  w_next = S_EXECR;
          c_op_itype:  w_next = S_EXECI;
          c_op_branch: w_next = S_BEQ;
          c_op_jal:    w_next = S_JAL;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_next = S_HALT;
`else
            w_retired = 1'b1;
            w_next    = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = c_srca_a;
        w_alu_src_b = c_srcb_imm;
        w_next      = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = c_adr_aluout;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = c_res_rdata;
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe held for the whole access; memory commits on mem_ready
        w_adr_src   = c_adr_aluout;
        w_mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_retired = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        w_alu_src_a   = c_srca_a;
        w_alu_src_b   = (r_state == S_EXECI) ? c_srcb_imm : c_srcb_b;
        w_alu_control = w_exec_alu;
        w_next        = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (w_dec_unsup) w_next = S_HALT;
`endif
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a   = c_srca_a;
        w_alu_control = c_alu_sub;
        w_pc_write    = bus.zero;
        w_retired     = 1'b1;
        w_next        = S_FETCH;
      end
      S_JAL: begin
        // Target from ALUOut loads PC while OldPC+4 lands in ALUOut for rd
        w_alu_src_a = c_srca_oldpc;
        w_alu_src_b = c_srcb_four;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_illegal <= 1'b0;
    else if (w_next == S_HALT)  r_illegal <= 1'b1;
  end

  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  // Strobes are forced low combinationally while reset is held, since
  // FETCH would otherwise pass mem_ready through to pc_write/ir_write
  assign bus.pc_write      = w_pc_write  & ~reset;
  assign bus.ir_write      = w_ir_write  & ~reset;
  assign bus.mem_write     = w_mem_write & ~reset;
  assign bus.reg_write     = w_reg_write & ~reset;
  assign bus.instr_retired = w_retired   & ~reset;
  assign bus.adr_src       = w_adr_src;
  assign bus.result_src    = w_result_src;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_control   = w_alu_control;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A driver issues
//                directed and random instructions and pushes the expected
//                per-instruction behaviour into a queue; a monitor collects
//                strobe counts over each instruction and compares on every
//                instr_retired pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    int         rw;
    int         pcw;
    int         mw;
    int         irw;
    int         adr1;
    logic [1:0] res;
    logic       chk_alu;
    logic [3:0] alu;
  } rec_t;

  rec_t exp_q[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: ALU operation implied by the instruction's arithmetic meaning
  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic b30);
    logic [3:0] r;
    case (f3)
      3'd0:    r = (op == 7'h33 && b30) ? 4'd6 : 4'd2;
      3'd1:    r = 4'd3;
      3'd2:    r = 4'd7;
      3'd4:    r = 4'd4;
      3'd5:    r = b30 ? 4'd2 : 4'd5;
      3'd6:    r = 4'd1;
      3'd7:    r = 4'd0;
      default: r = 4'd2;
    endcase
    return r;
  endfunction

  // Reference: what one instruction looks like from the outside, given
  // fs fetch wait cycles, ms data-memory wait cycles and the zero flag
  function automatic rec_t model(input logic [31:0] ins, input int fs, input int ms, input logic z);
    rec_t r;
    r.cycles = 2 + fs; r.rw = 0; r.pcw = 1; r.mw = 0; r.irw = 1; r.adr1 = 0;
    r.res = 2'd0; r.chk_alu = 1'b1; r.alu = 4'd2;
    case (ins[6:0])
      7'h03: begin r.cycles = 5 + fs + ms; r.rw = 1; r.res = 2'd1; r.adr1 = ms + 1; end
      7'h23: begin r.cycles = 4 + fs + ms; r.mw = ms + 1; r.adr1 = ms + 1; end
      7'h33, 7'h13: begin
        r.cycles = 4 + fs; r.rw = 1; r.alu = ref_alu(ins[6:0], ins[14:12], ins[30]);
      end
      7'h63: begin r.cycles = 3 + fs; r.pcw = 1 + int'(z); r.alu = 4'd6; end
      7'h6F: begin r.cycles = 4 + fs; r.pcw = 2; r.rw = 1; end
      default: r.chk_alu = 1'b0;
    endcase
    return r;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int fs, input int ms, input logic z);
    rec_t e;
    logic is_mem;
    int   mem_lo;
    e      = model(ins, fs, ms, z);
    is_mem = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
    mem_lo = fs + 3;
    exp_q.push_back(e);
    bus.opcode = ins[6:0];
    bus.funct3 = ins[14:12];
    bus.funct7 = ins[31:25];
    bus.zero   = z;
    for (int k = 0; k < e.cycles; k++) begin
      if (k < fs)                                         bus.mem_ready = 1'b0;
      else if (k == fs)                                   bus.mem_ready = 1'b1;
      else if (is_mem && k >= mem_lo && k < mem_lo + ms)  bus.mem_ready = 1'b0;
      else if (is_mem && k == mem_lo + ms)                bus.mem_ready = 1'b1;
      else                                                bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // Monitor: accumulate observations per instruction, compare on retire
  int         m_cyc, m_rw, m_pcw, m_mw, m_irw, m_adr1, m_irw_at;
  logic [1:0] m_res;
  logic [3:0] m_alu;
  logic       m_alu_seen;

  task automatic m_clear();
    m_cyc = 0; m_rw = 0; m_pcw = 0; m_mw = 0; m_irw = 0; m_adr1 = 0; m_irw_at = 0;
    m_res = 2'd0; m_alu = 4'd0; m_alu_seen = 1'b0;
  endtask

  initial begin
    rec_t e;
    m_clear();
    forever begin
      @(negedge clk);
      if (reset) begin
        m_clear();
      end else begin
        m_cyc++;
        if (bus.reg_write) begin m_rw++; m_res = bus.result_src; end
        if (bus.pc_write)  m_pcw++;
        if (bus.mem_write) m_mw++;
        if (bus.adr_src)   m_adr1++;
        if (bus.ir_write)  begin m_irw++; m_irw_at = m_cyc; end
        if (m_irw > 0 && m_cyc == m_irw_at + 2) begin m_alu = bus.alu_control; m_alu_seen = 1'b1; end
        if (bus.instr_retired) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("cycles",    m_cyc,  e.cycles);
            chk("reg_write", m_rw,   e.rw);
            chk("pc_write",  m_pcw,  e.pcw);
            chk("mem_write", m_mw,   e.mw);
            chk("ir_write",  m_irw,  e.irw);
            chk("adr_src",   m_adr1, e.adr1);
            if (e.rw > 0) chk("result_src", m_res, e.res);
            if (e.chk_alu) begin
              chk("alu_seen", m_alu_seen, 1'b1);
              chk("alu_control", m_alu, e.alu);
            end
          end
          m_clear();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0]  ops [7];
    logic [31:0] ins;
    int          nops;
    checks = 0;
    errors = 0;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h7F};

    reset = 1'b1;
    bus.opcode = 7'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_write",   bus.pc_write,      1'b0);
    chk("rst_ir_write",   bus.ir_write,      1'b0);
    chk("rst_mem_write",  bus.mem_write,     1'b0);
    chk("rst_reg_write",  bus.reg_write,     1'b0);
    chk("rst_retired",    bus.instr_retired, 1'b0);
    chk("rst_illegal",    bus.illegal,       1'b0);
    chk("rst_adr_src",    bus.adr_src,       1'b0);
    chk("rst_result_src", bus.result_src,    2'd2);
    chk("rst_alu_src_a",  bus.alu_src_a,     2'd0);
    chk("rst_alu_src_b",  bus.alu_src_b,     2'd2);
    reset = 1'b0;

    // Directed cases
    run_instr(32'h002081B3, 0, 0, 1'b0);  // ADD x3,x1,x2
    run_instr(32'h40208233, 1, 0, 1'b0);  // SUB
    run_instr(32'h0000A183, 0, 2, 1'b0);  // LW, 2 wait cycles in MEMREAD
    run_instr(32'h00208063, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00208063, 0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h0030A023, 0, 1, 1'b0);  // SW, 1 wait cycle in MEMWRITE
    run_instr(32'h008000EF, 2, 0, 1'b0);  // JAL
    run_instr(32'h4010D093, 0, 0, 1'b0);  // SRAI

    // Random traffic
    nops = 150;
    for (int n = 0; n < nops; n++) begin
      ins = $urandom;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ins[6:0] = ops[$urandom_range(0, 5)];
      if (ins[14:12] == 3'd3) ins[14:12] = 3'd0;
      if (ins[14:12] == 3'd5) ins[30] = 1'b0;
`else
      ins[6:0] = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
`endif
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Unsupported opcode 0x7F
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    bus.opcode = 7'h7F; bus.funct3 = 3'h7; bus.funct7 = 7'h7F; bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("halt_illegal",   bus.illegal,       1'b1);
      chk("halt_pc_write",  bus.pc_write,      1'b0);
      chk("halt_ir_write",  bus.ir_write,      1'b0);
      chk("halt_reg_write", bus.reg_write,     1'b0);
      chk("halt_mem_write", bus.mem_write,     1'b0);
      chk("halt_retired",   bus.instr_retired, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk("halt_reset_illegal", bus.illegal, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
`else
    run_instr(32'h0000007F, 0, 0, 1'b0);
    chk("nop_illegal_tied", bus.illegal, 1'b0);
`endif

    // Reset in the middle of a stalled store
    bus.opcode = 7'h23; bus.funct3 = 3'h2; bus.funct7 = 7'h0; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    #2;
    chk("sw_mem_write_pre_reset", bus.mem_write, 1'b1);
    reset = 1'b1;
    #1;
    chk("sw_mem_write_reset", bus.mem_write, 1'b0);
    chk("sw_adr_src_reset",   bus.adr_src,   1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(32'h002081B3, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
